bram_readback_checker: RTL
==========================

BRAM_READBACK_CHECKER -- requirements
Module: bram_readback_checker

Interface
REQ-001 Parameter ADDR_W, default 10, address width; depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 18, read data width.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles from ren/addr to rdata; legal range 1..3.
REQ-004 Parameter SEED, default 0, expected word at address 0.
REQ-005 Parameter STEP, default 1, expected increment per address.
REQ-006 clock0  in  1  single clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin a full readback pass.
REQ-009 ren  out  1  read enable to the BRAM read port.
REQ-010 addr  out  ADDR_W  read address to the BRAM read port.
REQ-011 rdata  in  DATA_W  read data from the BRAM read port.
REQ-012 busy  out  1  high while a pass is in progress.
REQ-013 done  out  1  high from pass completion until the next accepted start or reset.
REQ-014 err  out  1  sticky mismatch flag for the current or last pass.
REQ-015 err_count  out  ADDR_W+1  number of mismatching words in the pass.
REQ-016 first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.

Function
REQ-017 The expected word for address k shall be (SEED + k*STEP) mod 2^DATA_W, generated incrementally with no multiplier.
REQ-018 The FSM shall have states IDLE, READ, DRAIN and DONE.
REQ-019 Start shall be accepted only in IDLE or DONE; start in READ or DRAIN shall be ignored.
REQ-020 On an accepted start, the block shall clear err, err_count and first_err_addr, drop done, and enter READ on the next cycle.
REQ-021 In READ, ren shall be 1 and addr shall step 0,1,...,2^ADDR_W-1, one address per cycle, with no gaps.
REQ-022 After the last address is issued, the FSM shall enter DRAIN for exactly RD_LAT cycles, with ren=0, and addr shall hold at its last value.
REQ-023 After DRAIN, the FSM shall enter DONE, with done=1 and busy=0; done shall stay high until an accepted start or reset.
REQ-024 busy shall be 1 exactly in READ and DRAIN.
REQ-025 Every issued read shall carry its address and expected word through an RD_LAT-deep valid pipeline.
REQ-026 rdata shall be compared only on the cycle its pipeline entry is valid.
REQ-027 On a mismatch, err_count shall increment by 1 and err shall set.
REQ-028 On the first mismatch of a pass, first_err_addr shall capture that entry's address.
REQ-029 err_count shall not saturate; its width holds the full depth 2^ADDR_W.
REQ-030 Outputs shall reach final values on the same cycle done rises; the last compare shall land in the final DRAIN cycle.
REQ-031 If start and the final compare coincide, start shall be ignored, because the FSM is still in DRAIN.
REQ-032 Address and expected-value counters shall wrap modulo 2^ADDR_W and 2^DATA_W respectively.

Reset
REQ-033 While reset is high: state=IDLE, ren=0, addr=0, busy=0, done=0, err=0, err_count=0, first_err_addr=0, all pipeline valids=0.
REQ-034 Reset asserted mid-pass shall abort the pass with no partial results retained; start sampled with reset high shall be ignored.

Structure
REQ-035 A shared package bram_chk_pkg shall hold the FSM state enum and the RD_LAT legal-range constants.
REQ-036 The valid/address/expected delay line shall be one sub-module, rd_valid_pipe, parameterised by depth and payload width.
REQ-037 The block shall be flat otherwise, with no memories inside it.

Verification
REQ-038 Healthy pass: a BRAM model preloaded with k, defaults, and a start pulse -> ren high for 1024 cycles; done rises 1025 cycles after READ entry; err=0; err_count=0.
REQ-039 Single fault: preload with k but word 37 = 0x00000 -> err=1, err_count=1, first_err_addr=37.
REQ-040 Pattern with wrap: SEED=0x3FFF0, STEP=3, model matching mod 2^18 -> err=0; word 6 expected 0x00002.
REQ-041 Latency: RD_LAT=3 with a matching 3-cycle model -> err=0, DRAIN lasts 3 cycles; the same model with RD_LAT=1 -> err_count=1023 (word 0 matches under zero-fill model).
REQ-042 Control: start pulsed at READ cycle 100 ignored; reset at READ cycle 500 -> all outputs 0 next cycle; a new start then completes a clean pass.
REQ-043 Back-to-back: start while done=1 after a failing pass -> err, err_count and first_err_addr clear on acceptance and the new pass rechecks all words.

Source files
------------

// File: rtl/bram_chk_pkg.sv
// Purpose: shared FSM state encoding and read-latency limits for the BRAM readback checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_chk_pkg;

    // Read latencies the checker supports, from addr/ren to rdata.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Width of the DRAIN down-counter. It must hold RD_LAT_MAX-1.
    localparam int DRAIN_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // True when a read latency is inside the supported range.
    function automatic logic rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// Purpose: fixed-depth valid + payload delay line that aligns issued reads with their returning data.
// Latency: DEPTH cycles from vld_i/dat_i to vld_o/dat_o.
// Backpressure: none; the line shifts every cycle.
//
// Ports:
//   clk_i  - rising-edge clock
//   rst_i  - synchronous active-high reset; clears every stage valid
//   vld_i  - entry valid at the head of the line
//   dat_i  - entry payload (W bits)
//   vld_o  - entry valid at the tail, DEPTH cycles later
//   dat_o  - entry payload at the tail
module rd_valid_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0][W-1:0] dat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= dat_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/bram_readback_checker.sv
// Purpose: sweeps every BRAM address once per start and compares each word against SEED + k*STEP.
// Latency: pass completes (done) 2^ADDR_W + RD_LAT cycles after entering READ.
// Backpressure: none; one read per cycle is issued unconditionally and start is ignored while busy.
//
// Ports:
//   clock0         - rising-edge clock
//   reset          - synchronous active-high reset; aborts any pass in progress
//   start          - one-cycle request for a readback pass (accepted in IDLE or DONE)
//   ren, addr      - BRAM read port request
//   rdata          - BRAM read data, RD_LAT cycles after ren/addr
//   busy           - high in READ and DRAIN
//   done           - high from pass completion until the next accepted start or reset
//   err            - sticky mismatch flag for the current or last pass
//   err_count      - mismatching words seen in the pass (holds the full depth)
//   first_err_addr - address of the first mismatch, 0 if none
module bram_readback_checker
    import bram_chk_pkg::*;
#(
    parameter int          ADDR_W = 10,
    parameter int          DATA_W = 18,
    parameter int          RD_LAT = 1,
    parameter int unsigned SEED   = 0,
    parameter int unsigned STEP   = 1
) (
    input  logic              clock0,
    input  logic              reset,
    input  logic              start,
    output logic              ren,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("bram_readback_checker: RD_LAT must be within 1..3");
    end

    localparam logic [DATA_W-1:0]  SEED_W    = DATA_W'(SEED);
    localparam logic [DATA_W-1:0]  STEP_W    = DATA_W'(STEP);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]    CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_INI = DRAIN_W'(RD_LAT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE = DRAIN_W'(1);
    localparam int                 PAY_W     = ADDR_W + DATA_W;

    chk_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   exp_q,   exp_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                err_q,   err_d;
    logic [ADDR_W:0]     cnt_q,   cnt_d;
    logic [ADDR_W-1:0]   ferr_q,  ferr_d;

    logic                start_ok;
    logic                chk_vld;
    logic [PAY_W-1:0]    chk_pay;
    logic [ADDR_W-1:0]   chk_addr;
    logic [DATA_W-1:0]   chk_exp;
    logic                mismatch;

    // Each issued read carries its address and expected word so the compare
    // lines up with rdata regardless of RD_LAT.
    rd_valid_pipe #(
        .DEPTH (RD_LAT),
        .W     (PAY_W)
    ) u_rd_valid_pipe (
        .clk_i (clock0),
        .rst_i (reset),
        .vld_i (ren),
        .dat_i ({addr_q, exp_q}),
        .vld_o (chk_vld),
        .dat_o (chk_pay)
    );

    assign chk_addr = chk_pay[PAY_W-1:DATA_W];
    assign chk_exp  = chk_pay[DATA_W-1:0];
    assign mismatch = chk_vld && (rdata != chk_exp);

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        exp_d   = exp_q;
        drain_d = drain_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ferr_d  = ferr_q;

        // Compare results first; an accepted start below overrides them, but
        // the pipeline is always empty in IDLE/DONE so they never collide.
        if (mismatch) begin
            err_d = 1'b1;
            cnt_d = cnt_q + CNT_ONE;
            if (!err_q) begin
                ferr_d = chk_addr;
            end
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                    exp_d   = SEED_W;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    ferr_d  = '0;
                end
            end
            ST_READ: begin
                // Expected word advances by addition only; both counters wrap
                // naturally at their widths.
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INI;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    exp_d  = exp_q + STEP_W;
                end
            end
            ST_DRAIN: begin
                // The last compare lands in the final DRAIN cycle, so DONE
                // sees the finished results.
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            exp_q   <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            exp_q   <= exp_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
        end
    end

    assign ren            = (state_q == ST_READ);
    assign busy           = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign addr           = addr_q;
    assign err            = err_q;
    assign err_count      = cnt_q;
    assign first_err_addr = ferr_q;

endmodule
